// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder; master drives requests, slave is the adder.
// Pure wiring, no latency of its own.
// No backpressure: start is only honoured when the adder is idle or done.
// Optional carry-in guarded by SERIAL_ADDER_CIN_EN.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             serial_adder_start;
    logic [WIDTH-1:0] serial_adder_a;
    logic [WIDTH-1:0] serial_adder_b;
`ifdef SERIAL_ADDER_CIN_EN
    logic             serial_adder_cin;
`endif
    logic             serial_adder_busy;
    logic             serial_adder_done;
    logic [WIDTH-1:0] serial_adder_sum;
    logic             serial_adder_carry;

`ifdef SERIAL_ADDER_CIN_EN
    modport master (
        output serial_adder_start, serial_adder_a, serial_adder_b, serial_adder_cin,
        input  serial_adder_busy, serial_adder_done, serial_adder_sum, serial_adder_carry
    );
    modport slave (
        input  serial_adder_start, serial_adder_a, serial_adder_b, serial_adder_cin,
        output serial_adder_busy, serial_adder_done, serial_adder_sum, serial_adder_carry
    );
`else
    modport master (
        output serial_adder_start, serial_adder_a, serial_adder_b,
        input  serial_adder_busy, serial_adder_done, serial_adder_sum, serial_adder_carry
    );
    modport slave (
        input  serial_adder_start, serial_adder_a, serial_adder_b,
        output serial_adder_busy, serial_adder_done, serial_adder_sum, serial_adder_carry
    );
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-add step per clock, LSB first, result shifted in from the MSB side.
// Latency WIDTH+1 edges from the accepting start edge to the cycle with done high.
// No backpressure: start is ignored (not queued) while busy; accepted in IDLE or DONE for back-to-back use.
// Optional carry-in port enabled by defining SERIAL_ADDER_CIN_EN.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          serial_adder_clk,
    input  logic          serial_adder_rst,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;

    logic             sum_bit;
    logic             c_next;
    logic             c_init;

    // One full-add cell: the half-adder pair chained through the carry register.
    assign sum_bit = a_sh[0] ^ b_sh[0] ^ c;
    assign c_next  = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);

`ifdef SERIAL_ADDER_CIN_EN
    assign c_init = bus.serial_adder_cin;
`else
    assign c_init = 1'b0;
`endif

    // Control FSM with all outputs registered; reset aborts any operation without a done pulse.
    always_ff @(posedge serial_adder_clk) begin
        if (serial_adder_rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.serial_adder_start) begin
                        a_sh  <= bus.serial_adder_a;
                        b_sh  <= bus.serial_adder_b;
                        c     <= c_init;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    sum  <= {sum_bit, sum[WIDTH-1:1]};
                    c    <= c_next;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        carry <= c_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (bus.serial_adder_start) begin
                        a_sh  <= bus.serial_adder_a;
                        b_sh  <= bus.serial_adder_b;
                        c     <= c_init;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.serial_adder_busy  = busy;
    assign bus.serial_adder_done  = done;
    assign bus.serial_adder_sum   = sum;
    assign bus.serial_adder_carry = carry;
endmodule
